// File: rtl/sdram_wb_bridge_if.sv
// CPU-side SDRAM bus bundle between the board master and sdram_wb_bridge.
//   wb_stb   : transaction strobe, held by the master until wb_ack
//   wb_we    : 1 = write, 0 = read
//   wb_sel   : byte select, [1] = high byte, [0] = low byte
//   wb_adr   : 21-bit word address
//   wb_dat_i : write data (master -> bridge)
//   wb_dat_o : read data (bridge -> master)
//   wb_ack   : transaction acknowledge (bridge -> master)
`default_nettype none

interface sdram_wb_bridge_if;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic [20:0] wb_adr;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        output wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

`default_nettype wire

// File: rtl/sdram_wb_bridge.sv
// Bridge from the CPU-side SDRAM bus to the SDRAM controller request/ack port.
// Latches each accepted transaction, holds a write or read request until the
// controller acks it, then returns a delayed, strobe-qualified ack. A timeout
// guard forces completion (with 16'hFFFF read data) if the controller never acks.
//   clk, rst_n        : controller clock, asynchronous active-low reset
//   wb (slave)        : CPU bus (stb/we/sel/adr/dat_i in, dat_o/ack out)
//   sdr_init_done     : controller initialisation complete
//   sdr_wr_req/rd_req : registered requests to the controller
//   sdr_wr_ack/rd_ack : 1-cycle controller acks
//   sdr_rdata         : controller read data
//   sdr_addr/wdata/byteen : latched address, write data and byte enables
//   dm_l, dm_h        : PHY data masks, 1 = byte masked
//   timeout_err       : sticky timeout flag, cleared only by reset
//   busy              : FSM not idle
`default_nettype none

module sdram_wb_bridge #(
    parameter int unsigned ACK_DELAY = 2,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_wb_bridge_if.slave      wb,
    input  logic                  sdr_init_done,
    output logic                  sdr_wr_req,
    output logic                  sdr_rd_req,
    input  logic                  sdr_wr_ack,
    input  logic                  sdr_rd_ack,
    input  logic [15:0]           sdr_rdata,
    output logic [21:0]           sdr_addr,
    output logic [15:0]           sdr_wdata,
    output logic [1:0]            sdr_byteen,
    output logic                  dm_l,
    output logic                  dm_h,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned ADR_W = 21;
    localparam int unsigned DAT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DLY,
        ST_ACK,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]   r_wdata;
    logic [1:0]         r_sel;
    logic [1:0]         r_dm;          // {dm_h, dm_l}
    logic               r_wr_req;
    logic               r_rd_req;
    logic [DAT_W-1:0]   r_dat_o;
    logic               r_timeout_err;
    logic               r_busy;

    logic               w_accept;
    logic               w_timeout;
    logic               w_dly_last;
    logic               w_ctrl_ack;
    logic               w_req_we;

    assign w_ctrl_ack = sdr_wr_ack | sdr_rd_ack;
    // Direction of the request being held: the incoming one on accept, else the latched one.
    assign w_req_we   = w_accept ? wb.wb_we : r_we;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_dly_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb.wb_stb && sdr_init_done) begin
                    w_state_nxt = ST_REQ;
                    w_accept    = 1'b1;
                end
            end
            ST_REQ: begin
                // An ack wins over a timeout landing in the same cycle.
                if (w_ctrl_ack) begin
                    w_state_nxt = ST_DLY;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_ACK;
                    w_timeout   = 1'b1;
                end
            end
            ST_DLY: begin
                if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
                    w_dly_last  = 1'b1;
                    // Strobe gone means the master abandoned the access: finish silently.
                    w_state_nxt = wb.wb_stb ? ST_ACK : ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!wb.wb_stb) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!wb.wb_stb) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase counter: restarts on every state change, runs only while waiting in REQ/DLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ || r_state == ST_DLY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Transaction latch and PHY masks, captured on acceptance only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_dm    <= 2'b11;
        end else if (w_accept) begin
            r_we    <= wb.wb_we;
            r_adr   <= wb.wb_adr;
            r_wdata <= wb.wb_dat_i;
            r_sel   <= wb.wb_sel;
            // Reads always transfer the full word.
            r_dm    <= wb.wb_we ? ~wb.wb_sel : 2'b00;
        end
    end

    // Registered controller requests, read data, error flag and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_req      <= 1'b0;
            r_rd_req      <= 1'b0;
            r_dat_o       <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_wr_req <= (w_state_nxt == ST_REQ) &&  w_req_we;
            r_rd_req <= (w_state_nxt == ST_REQ) && !w_req_we;
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_dat_o       <= 16'hFFFF;
            end else if (w_dly_last && !r_we) begin
                r_dat_o       <= sdr_rdata;
            end
        end
    end

    assign wb.wb_ack  = wb.wb_stb && (r_state == ST_ACK);
    assign wb.wb_dat_o = r_dat_o;
    assign sdr_wr_req  = r_wr_req;
    assign sdr_rd_req  = r_rd_req;
    assign sdr_addr    = {1'b0, r_adr};
    assign sdr_wdata   = r_wdata;
    assign sdr_byteen  = r_sel;
    assign dm_h        = r_dm[1];
    assign dm_l        = r_dm[0];
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sdram_wb_bridge.sv
// Directed self-checking bench for sdram_wb_bridge (ACK_DELAY=2, TIMEOUT=1023).
`timescale 1ns/1ps

module tb_sdram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdr_init_done;
    logic        sdr_wr_req, sdr_rd_req;
    logic        sdr_wr_ack, sdr_rd_ack;
    logic [15:0] sdr_rdata;
    logic [21:0] sdr_addr;
    logic [15:0] sdr_wdata;
    logic [1:0]  sdr_byteen;
    logic        dm_l, dm_h, timeout_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by do_txn
    int          obs_req_cyc;
    logic        obs_wrong_req;
    logic        obs_got_ack;
    int          obs_ack_lat;
    logic [15:0] obs_dat;
    logic [1:0]  obs_dm;
    logic [21:0] obs_addr;
    logic [15:0] obs_wdata;
    logic [1:0]  obs_byteen;
    logic [3:0]  obs_post;

    sdram_wb_bridge_if bus();

    sdram_wb_bridge #(.ACK_DELAY(2), .TIMEOUT(1023)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (bus),
        .sdr_init_done (sdr_init_done),
        .sdr_wr_req    (sdr_wr_req),
        .sdr_rd_req    (sdr_rd_req),
        .sdr_wr_ack    (sdr_wr_ack),
        .sdr_rd_ack    (sdr_rd_ack),
        .sdr_rdata     (sdr_rdata),
        .sdr_addr      (sdr_addr),
        .sdr_wdata     (sdr_wdata),
        .sdr_byteen    (sdr_byteen),
        .dm_l          (dm_l),
        .dm_h          (dm_h),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Runs one transaction with a controller that acks after ack_after request
    // cycles (0 = never). Inputs change and outputs are sampled on negedges.
    task automatic do_txn(input logic we, input logic [1:0] sel, input logic [20:0] adr,
                          input logic [15:0] dat, input int ack_after);
        int t;
        int ack_cyc;
        t = 0;
        ack_cyc = -1;
        obs_req_cyc = 0;
        obs_wrong_req = 1'b0;
        obs_got_ack = 1'b0;
        obs_ack_lat = -1;
        obs_dat = 16'hxxxx;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = we;
        bus.wb_sel   = sel;
        bus.wb_adr   = adr;
        bus.wb_dat_i = dat;
        @(negedge clk);
        obs_dm     = {dm_h, dm_l};
        obs_addr   = sdr_addr;
        obs_wdata  = sdr_wdata;
        obs_byteen = sdr_byteen;
        while ((sdr_wr_req || sdr_rd_req) && t < 1100) begin
            obs_req_cyc++;
            if (we ? sdr_rd_req : sdr_wr_req) obs_wrong_req = 1'b1;
            if (ack_after != 0 && obs_req_cyc == ack_after) begin
                if (we) sdr_wr_ack = 1'b1;
                else    sdr_rd_ack = 1'b1;
                ack_cyc = t;
            end
            @(negedge clk);
            sdr_wr_ack = 1'b0;
            sdr_rd_ack = 1'b0;
            t++;
        end
        while (!bus.wb_ack && t < 1200) begin
            @(negedge clk);
            t++;
        end
        if (bus.wb_ack) begin
            obs_got_ack = 1'b1;
            obs_ack_lat = (ack_cyc >= 0) ? t - ack_cyc : -1;
            obs_dat     = bus.wb_dat_o;
        end
        bus.wb_stb = 1'b0;
        @(negedge clk);
        obs_post = {bus.wb_ack, busy, sdr_wr_req, sdr_rd_req};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sdr_init_done = 1'b1;
        sdr_wr_ack = 1'b0;
        sdr_rd_ack = 1'b0;
        sdr_rdata = 16'h0000;
        bus.wb_stb = 1'b0;
        bus.wb_we = 1'b0;
        bus.wb_sel = 2'b00;
        bus.wb_adr = '0;
        bus.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sdr_wr_req, sdr_rd_req, bus.wb_ack, busy, timeout_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 00000",
                     {sdr_wr_req, sdr_rd_req, bus.wb_ack, busy, timeout_err});
        end
        n_checks++;
        if ({dm_h, dm_l} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_dm: got %b expected 11", {dm_h, dm_l});
        end
        n_checks++;
        if ({bus.wb_dat_o, sdr_addr, sdr_wdata, sdr_byteen} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_data: dat_o=%h addr=%h wdata=%h byteen=%b expected all 0",
                     bus.wb_dat_o, sdr_addr, sdr_wdata, sdr_byteen);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sdr_wr_req, sdr_rd_req, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 000", {sdr_wr_req, sdr_rd_req, busy});
        end
    endtask

    task automatic test_write;
        do_txn(1'b1, 2'b11, 21'h00100, 16'hA55A, 3);
        n_checks++;
        if (obs_req_cyc !== 3 || obs_wrong_req !== 1'b0) begin
            n_fail++;
            $display("FAIL write_req: got %0d cycles wrong=%b expected 3 cycles wrong=0",
                     obs_req_cyc, obs_wrong_req);
        end
        n_checks++;
        if ({obs_dm, obs_byteen} !== 4'b0011) begin
            n_fail++;
            $display("FAIL write_dm_byteen: got %b expected 0011", {obs_dm, obs_byteen});
        end
        n_checks++;
        if (obs_addr !== 22'h000100 || obs_wdata !== 16'hA55A) begin
            n_fail++;
            $display("FAIL write_latch: got addr=%h wdata=%h expected 000100 a55a", obs_addr, obs_wdata);
        end
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_ack_lat !== 3) begin
            n_fail++;
            $display("FAIL write_ack_latency: got ack=%b lat=%0d expected ack=1 lat=3",
                     obs_got_ack, obs_ack_lat);
        end
        n_checks++;
        if (obs_post !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_return_idle: got %b expected 0000", obs_post);
        end
    endtask

    task automatic test_read;
        sdr_rdata = 16'h1234;
        do_txn(1'b0, 2'b01, 21'h00100, 16'h0000, 2);
        n_checks++;
        if (obs_req_cyc !== 2 || obs_wrong_req !== 1'b0) begin
            n_fail++;
            $display("FAIL read_req: got %0d cycles wrong=%b expected 2 cycles wrong=0",
                     obs_req_cyc, obs_wrong_req);
        end
        n_checks++;
        if (obs_dm !== 2'b00) begin
            n_fail++;
            $display("FAIL read_dm: got %b expected 00", obs_dm);
        end
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_dat !== 16'h1234 || obs_ack_lat !== 3) begin
            n_fail++;
            $display("FAIL read_data: got ack=%b dat=%h lat=%0d expected ack=1 dat=1234 lat=3",
                     obs_got_ack, obs_dat, obs_ack_lat);
        end
    endtask

    task automatic test_byte_write;
        do_txn(1'b1, 2'b10, 21'h1F00F, 16'hCD00, 1);
        n_checks++;
        if ({dm_h, dm_l} !== 2'b01 || obs_dm !== 2'b01) begin
            n_fail++;
            $display("FAIL byte_dm: got req=%b now=%b expected dm_h=0 dm_l=1 (01)", obs_dm, {dm_h, dm_l});
        end
        n_checks++;
        if (obs_byteen !== 2'b10 || obs_addr !== 22'h01F00F) begin
            n_fail++;
            $display("FAIL byte_byteen_addr: got byteen=%b addr=%h expected 10 01f00f", obs_byteen, obs_addr);
        end
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_ack_lat !== 3) begin
            n_fail++;
            $display("FAIL byte_ack: got ack=%b lat=%0d expected ack=1 lat=3", obs_got_ack, obs_ack_lat);
        end
    endtask

    task automatic test_timeout;
        do_txn(1'b0, 2'b11, 21'h1ABCD, 16'h0000, 0);
        n_checks++;
        if (obs_req_cyc !== 1023) begin
            n_fail++;
            $display("FAIL timeout_req_len: got %0d cycles expected 1023", obs_req_cyc);
        end
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_dat !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL timeout_ack_data: got ack=%b dat=%h expected ack=1 dat=ffff", obs_got_ack, obs_dat);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || obs_post !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_flag: got err=%b post=%b expected err=1 post=0000", timeout_err, obs_post);
        end
    endtask

    task automatic test_stb_drop;
        int   req_cnt;
        logic saw_ack;
        req_cnt = 0;
        saw_ack = 1'b0;
        bus.wb_stb = 1'b1;
        bus.wb_we = 1'b1;
        bus.wb_sel = 2'b11;
        bus.wb_adr = 21'h00200;
        bus.wb_dat_i = 16'h0F0F;
        @(negedge clk);
        bus.wb_stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sdr_wr_req) req_cnt++;
            if (bus.wb_ack) saw_ack = 1'b1;
            if (i == 1) sdr_wr_ack = 1'b1;
            @(negedge clk);
            sdr_wr_ack = 1'b0;
        end
        n_checks++;
        if (req_cnt !== 2) begin
            n_fail++;
            $display("FAIL stb_drop_req: got %0d cycles expected 2", req_cnt);
        end
        n_checks++;
        if (saw_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stb_drop_noack: got ack_seen=%b busy=%b expected 0 0", saw_ack, busy);
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
        sdr_rdata = 16'hBEEF;
        do_txn(1'b0, 2'b11, 21'h00200, 16'h0000, 1);
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_dat !== 16'hBEEF || obs_ack_lat !== 3) begin
            n_fail++;
            $display("FAIL stb_drop_next: got ack=%b dat=%h lat=%0d expected ack=1 dat=beef lat=3",
                     obs_got_ack, obs_dat, obs_ack_lat);
        end
    endtask

    task automatic test_init_and_reset;
        logic seen;
        seen = 1'b0;
        sdr_init_done = 1'b0;
        bus.wb_stb = 1'b1;
        bus.wb_we = 1'b1;
        bus.wb_sel = 2'b01;
        bus.wb_adr = 21'h0000F;
        bus.wb_dat_i = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sdr_wr_req || sdr_rd_req || busy || bus.wb_ack) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL init_hold: got activity=%b expected 0", seen);
        end
        sdr_init_done = 1'b1;
        do_txn(1'b1, 2'b01, 21'h0000F, 16'h1111, 1);
        n_checks++;
        if (obs_got_ack !== 1'b1 || obs_req_cyc !== 1 || obs_dm !== 2'b10 || obs_wdata !== 16'h1111) begin
            n_fail++;
            $display("FAIL init_proceed: got ack=%b req=%0d dm=%b wdata=%h expected 1 1 10 1111",
                     obs_got_ack, obs_req_cyc, obs_dm, obs_wdata);
        end
        // Reset asserted while the bridge waits in DLY.
        bus.wb_stb = 1'b1;
        bus.wb_we = 1'b1;
        bus.wb_sel = 2'b11;
        bus.wb_adr = 21'h00055;
        bus.wb_dat_i = 16'h7777;
        @(negedge clk);
        sdr_wr_ack = 1'b1;
        @(negedge clk);
        sdr_wr_ack = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || sdr_wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_dly: got busy=%b wr_req=%b expected 1 0", busy, sdr_wr_req);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sdr_wr_req, sdr_rd_req, bus.wb_ack, busy, timeout_err, dm_h, dm_l} !== 7'b0000011 ||
            {bus.wb_dat_o, sdr_addr, sdr_wdata, sdr_byteen} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_mid_dly: got ctl=%b dat_o=%h addr=%h wdata=%h byteen=%b expected 0000011 and zeros",
                     {sdr_wr_req, sdr_rd_req, bus.wb_ack, busy, timeout_err, dm_h, dm_l},
                     bus.wb_dat_o, sdr_addr, sdr_wdata, sdr_byteen);
        end
        bus.wb_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sdr_wr_req, busy, bus.wb_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 000", {sdr_wr_req, busy, bus.wb_ack});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_timeout();
        test_stb_drop();
        test_init_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
